// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with a pending-bit scoreboard and a
// sequential clear engine. It sits between decode/issue and writeback.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   rd_addr/rd_data   NUM_RD packed combinational read ports (port k = slice k)
//   rd_busy           pending bit for each read address
//   wa_*              write port A (wins over B on an address collision)
//   wb_*              write port B
//   iss_en/iss_addr   mark a register pending when its producer issues
//   clr_req/clr_busy  start / status of the one-entry-per-cycle clear engine
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wa_en,
  input  logic [AW-1:0]          wa_addr,
  input  logic [XLEN-1:0]        wa_data,
  input  logic                   wb_en,
  input  logic [AW-1:0]          wb_addr,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  input  logic                   clr_req,
  output logic                   clr_busy
);

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [AW-1:0]     clr_cnt;
  logic [XLEN-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]  pending;

  logic              wa_ok;
  logic              wb_ok;
  logic              iss_ok;
  logic [AW-1:0]     ra;

  // An address is backed by storage only if it is in range and is not the
  // hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Port B is suppressed on a collision so A's data is the one stored/bypassed.
  assign wa_ok  = wa_en && addr_ok(wa_addr);
  assign wb_ok  = wb_en && addr_ok(wb_addr) && !(wa_ok && (wa_addr == wb_addr));
  assign iss_ok = iss_en && addr_ok(iss_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      clr_busy <= 1'b0;
      pending  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wa_ok) begin
            mem[wa_addr]     <= wa_data;
            pending[wa_addr] <= 1'b0;
          end
          if (wb_ok) begin
            mem[wb_addr]     <= wb_data;
            pending[wb_addr] <= 1'b0;
          end
          // Issue is applied last so a new producer wins over a completing write.
          if (iss_ok) pending[iss_addr] <= 1'b1;
          if (clr_req) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          mem[clr_cnt]     <= '0;
          pending[clr_cnt] <= 1'b0;
          if (clr_cnt == CNT_LAST) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reads: stored contents, overridden by a same-cycle write when bypass is
  // enabled and the clear engine is idle (writes are not accepted during CLEAR).
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*AW +: AW];
      if (addr_ok(ra)) begin
        rd_data[k*XLEN +: XLEN] = mem[ra];
        rd_busy[k]              = pending[ra];
      end
      if ((BYPASS != 0) && (state == IDLE)) begin
        if (wa_ok && (wa_addr == ra)) begin
          rd_data[k*XLEN +: XLEN] = wa_data;
          rd_busy[k]              = iss_ok && (iss_addr == ra);
        end else if (wb_ok && (wb_addr == ra)) begin
          rd_data[k*XLEN +: XLEN] = wb_data;
          rd_busy[k]              = iss_ok && (iss_addr == ra);
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp. Three instances share one stimulus stream:
// dut0 (defaults), dut_nb (BYPASS=0) and dut_d24 (DEPTH=24). Stimulus pushes
// expected read/status values into a queue; a monitor drains it each negedge.
module tb_reg_file_mp;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2*AW-1:0] rd_addr;
  logic          wa_en, wb_en, iss_en, clr_req;
  logic [AW-1:0] wa_addr, wb_addr, iss_addr;
  logic [31:0]   wa_data, wb_data;

  logic [63:0] rd_data0, rd_data_nb, rd_data_d24;
  logic [1:0]  rd_busy0, rd_busy_nb, rd_busy_d24;
  logic        clr_busy0, clr_busy_nb, clr_busy_d24;

  always #5 clk = ~clk;

  reg_file_mp dut0 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .clr_req(clr_req), .clr_busy(clr_busy0));

  reg_file_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .clr_req(clr_req), .clr_busy(clr_busy_nb));

  reg_file_mp #(.DEPTH(24)) dut_d24 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_d24), .rd_busy(rd_busy_d24),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .clr_req(clr_req), .clr_busy(clr_busy_d24));

  // port = -1 selects clr_busy of the chosen instance; data is then ignored.
  typedef struct {
    int          dut;
    int          port;
    logic [31:0] data;
    logic        busy;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   n_fail    = 0;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [31:0] ad;
      logic        ab;
      e  = exp_q.pop_front();
      ad = '0;
      ab = 1'b0;
      case (e.dut)
        0:       begin ad = rd_data0[e.port*32 +: 32];    ab = rd_busy0[e.port];    end
        1:       begin ad = rd_data_nb[e.port*32 +: 32];  ab = rd_busy_nb[e.port];  end
        default: begin ad = rd_data_d24[e.port*32 +: 32]; ab = rd_busy_d24[e.port]; end
      endcase
      tests_run++;
      if (e.port < 0) begin
        ab = (e.dut == 0) ? clr_busy0 : (e.dut == 1) ? clr_busy_nb : clr_busy_d24;
        if (ab !== e.busy) begin
          n_fail++;
          $display("FAIL %s: clr_busy got %b expected %b", e.name, ab, e.busy);
        end
      end else if (ad !== e.data || ab !== e.busy) begin
        n_fail++;
        $display("FAIL %s: data/busy got %h/%b expected %h/%b", e.name, ad, ab, e.data, e.busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic expect_rd(input int d, input int p, input logic [31:0] data,
                           input logic busy, input string nm);
    exp_t e;
    e.dut = d; e.port = p; e.data = data; e.busy = busy; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic expect_busy(input int d, input logic busy, input string nm);
    expect_rd(d, -1, 32'h0, busy, nm);
  endtask

  task automatic idle_inputs();
    wa_en = 0; wb_en = 0; iss_en = 0; clr_req = 0;
  endtask

  initial begin
    rst_n = 0; rd_addr = '0; idle_inputs();
    wa_addr = '0; wb_addr = '0; iss_addr = '0; wa_data = '0; wb_data = '0;
    tick(); tick();
    rst_n = 1;

    // Reset state on every address, both ports
    for (int a = 0; a < 32; a++) begin
      set_rd(0, a); set_rd(1, 31 - a);
      expect_rd(0, 0, 32'h0, 1'b0, "reset_p0");
      expect_rd(0, 1, 32'h0, 1'b0, "reset_p1");
      tick();
    end
    expect_busy(0, 1'b0, "reset_clr_busy");

    // Dual write to distinct registers
    wa_en = 1; wa_addr = 3; wa_data = 32'h11;
    wb_en = 1; wb_addr = 4; wb_data = 32'h22;
    set_rd(0, 3); set_rd(1, 4);
    expect_rd(1, 0, 32'h0, 1'b0, "nb_old_r3");
    tick(); idle_inputs();
    expect_rd(0, 0, 32'h11, 1'b0, "dual_wr_r3");
    expect_rd(0, 1, 32'h22, 1'b0, "dual_wr_r4");
    expect_rd(1, 1, 32'h22, 1'b0, "nb_dual_wr_r4");
    tick();

    // Collision: A wins
    wa_en = 1; wa_addr = 7; wa_data = 32'hAAAA;
    wb_en = 1; wb_addr = 7; wb_data = 32'hBBBB;
    set_rd(0, 7);
    expect_rd(0, 0, 32'hAAAA, 1'b0, "collide_bypass_r7");
    tick(); idle_inputs();
    expect_rd(0, 0, 32'hAAAA, 1'b0, "collide_r7");
    expect_rd(1, 0, 32'hAAAA, 1'b0, "nb_collide_r7");
    tick();

    // Bypass vs no bypass
    wa_en = 1; wa_addr = 9; wa_data = 32'h1234;
    wb_en = 1; wb_addr = 10; wb_data = 32'h55;
    set_rd(0, 9); set_rd(1, 10);
    expect_rd(0, 0, 32'h1234, 1'b0, "bypass_a_r9");
    expect_rd(0, 1, 32'h55,   1'b0, "bypass_b_r10");
    expect_rd(1, 0, 32'h0,    1'b0, "nobypass_old_r9");
    tick(); idle_inputs();
    expect_rd(1, 0, 32'h1234, 1'b0, "nobypass_new_r9");
    tick();

    // Register 0 hardwired
    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF; iss_en = 1; iss_addr = 0;
    set_rd(0, 0);
    expect_rd(0, 0, 32'h0, 1'b0, "r0_same_cycle");
    tick(); idle_inputs();
    expect_rd(0, 0, 32'h0, 1'b0, "r0_after");
    tick();

    // Out of range on DEPTH=24 (in range on DEPTH=32)
    wa_en = 1; wa_addr = 30; wa_data = 32'hCAFE;
    set_rd(0, 30);
    expect_rd(2, 0, 32'h0, 1'b0, "oor_same_cycle");
    tick(); idle_inputs();
    expect_rd(2, 0, 32'h0,    1'b0, "oor_after");
    expect_rd(0, 0, 32'hCAFE, 1'b0, "d32_r30");
    tick();

    // Scoreboard on reg6
    iss_en = 1; iss_addr = 6; set_rd(1, 6);
    expect_rd(0, 1, 32'h0, 1'b0, "iss_same_cycle");
    tick(); idle_inputs();
    expect_rd(0, 1, 32'h0, 1'b1, "iss_pending");
    expect_rd(1, 1, 32'h0, 1'b1, "nb_iss_pending");
    tick();
    wb_en = 1; wb_addr = 6; wb_data = 32'h66;
    expect_rd(0, 1, 32'h66, 1'b0, "wr_bypass_clears_busy");
    expect_rd(1, 1, 32'h0,  1'b1, "nb_still_busy");
    tick(); idle_inputs();
    expect_rd(0, 1, 32'h66, 1'b0, "wr_cleared");
    expect_rd(1, 1, 32'h66, 1'b0, "nb_wr_cleared");
    tick();
    iss_en = 1; iss_addr = 6; wa_en = 1; wa_addr = 6; wa_data = 32'h77;
    expect_rd(0, 1, 32'h77, 1'b1, "iss_wr_same_bypass");
    tick(); idle_inputs();
    expect_rd(0, 1, 32'h77, 1'b1, "iss_wins");
    expect_rd(1, 1, 32'h77, 1'b1, "nb_iss_wins");
    tick();

    // Load registers 1..31
    for (int r = 1; r < 32; r++) begin
      wa_en = 1; wa_addr = AW'(r); wa_data = 32'h100 + r;
      tick();
    end
    idle_inputs();
    set_rd(0, 31); set_rd(1, 1);
    expect_rd(0, 0, 32'h11F, 1'b0, "load_r31");
    expect_rd(0, 1, 32'h101, 1'b0, "load_r1");
    tick();

    // Sequential clear
    clr_req = 1;
    expect_busy(0, 1'b0, "clr_req_cycle");
    tick(); clr_req = 0;
    for (int c = 0; c <= 32; c++) begin
      expect_busy(0, (c < 32), $sformatf("clr_busy_c%0d", c));
      if (c == 3) begin
        set_rd(0, 2); set_rd(1, 20);
        expect_rd(0, 0, 32'h0,   1'b0, "mid_clear_r2");
        expect_rd(0, 1, 32'h114, 1'b0, "mid_clear_r20");
      end
      if (c == 5) begin
        wa_en = 1; wa_addr = 25; wa_data = 32'hBAD; set_rd(0, 25);
        expect_rd(0, 0, 32'h119, 1'b0, "clear_no_bypass");
      end
      if (c == 6) wa_en = 0;
      if (c == 10) expect_rd(0, 0, 32'h119, 1'b0, "clear_wr_ignored");
      tick();
    end
    for (int a = 0; a < 32; a++) begin
      set_rd(0, a); set_rd(1, 31 - a);
      expect_rd(0, 0, 32'h0, 1'b0, "post_clear_p0");
      expect_rd(0, 1, 32'h0, 1'b0, "post_clear_p1");
      tick();
    end

    // Asynchronous reset with no clock edge
    wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
    tick(); idle_inputs();
    set_rd(0, 5);
    expect_rd(0, 0, 32'hDEADBEEF, 1'b0, "r5_loaded");
    tick();
    rst_n = 0;
    expect_rd(0, 0, 32'h0, 1'b0, "async_reset_r5");
    tick();
    rst_n = 1;
    tick();

    // Reset aborting a clear
    clr_req = 1;
    tick(); clr_req = 0;
    tick(); tick();
    expect_busy(0, 1'b1, "clear_running");
    tick();
    rst_n = 0;
    expect_busy(0, 1'b0, "reset_aborts_clear");
    tick();
    rst_n = 1;
    tick();
    expect_busy(0, 1'b0, "idle_after_abort");
    tick(); tick();

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
    $finish;
  end

endmodule
